score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Two-team scoreboard stage that sits directly downstream of the push-button debouncers.
- Consumes the debounced press pulses: increment/decrement per team, plus clear.
- Holds two 2-digit BCD scores, detects the win condition and locks the board until cleared.
- BCD digits feed the display multiplexer; a one-cycle change strobe feeds any sound or LED logic.

Parameters:
- WIN_SCORE, 21: decimal score that ends the game. Legal range 1..99; values outside this range are illegal and need not be handled.

Ports:
- clk      input   1  system clock; same clock the debouncers' dividers run from
- rst_n    input   1  synchronous active-low reset
- a_inc    input   1  debounced press, team A +1; may stay high for many clk cycles
- a_dec    input   1  debounced press, team A -1
- b_inc    input   1  debounced press, team B +1
- b_dec    input   1  debounced press, team B -1
- clr      input   1  debounced press, clear scores and unlock
- a_tens   output  4  team A tens digit (BCD)
- a_ones   output  4  team A ones digit (BCD)
- b_tens   output  4  team B tens digit (BCD)
- b_ones   output  4  team B ones digit (BCD)
- winner   output  2  bit0 = A reached WIN_SCORE, bit1 = B reached WIN_SCORE
- chg      output  1  one-cycle strobe on any score, winner or clear change

Behaviour:
- Reset
  - Synchronous: rst_n low at a clk posedge.
  - All digits 0, winner 2'b00, chg 0, state PLAY, edge-detect history cleared to 0.
- Edge detection (all five inputs)
  - Per input, two flops: s1 <= in, s2 <= s1; press = s1 & ~s2.
  - A pulse lasting N >= 1 clk cycles yields exactly one press.
  - Input high sampled at posedge k gives press during cycle k to k+1; outputs reflect the update after posedge k+1. Latency is 2 posedges.
- State machine: PLAY, LOCKED
  - PLAY, per team:
    - inc press only: +1 in BCD; ones 9 -> 0 with tens +1; saturate at 99 with no change and no chg.
    - dec press only: -1 in BCD; ones 0 -> 9 with tens -1; saturate at 00 with no change and no chg.
    - inc and dec press same cycle: no change.
  - Teams update independently in the same cycle.
  - PLAY -> LOCKED on the posedge where either new score equals WIN_SCORE.
    - winner set on that same posedge.
    - Both teams reaching it together sets winner = 2'b11.
  - LOCKED: all inc/dec presses ignored; scores and winner hold.
  - clr press, either state: next posedge gives scores 00, winner 00, state PLAY, chg 1.
    - clr overrides any inc/dec press in the same cycle.
- chg
  - High for exactly one cycle, the cycle after the posedge that changed any output register (excluding chg itself).
  - clr while already 00/PLAY still pulses chg.
- Reset mid-press
  - Edge history cleared.
  - A button still held when rst_n releases produces a press on the first cycle after reset. This is accepted: debounce pulses are short.
- Arithmetic
  - Scores are stored as BCD only; no binary counter.
  - Win compare uses localparams WIN_TENS = WIN_SCORE/10 and WIN_ONES = WIN_SCORE%10.

Decomposition:
- Shared package:
  - state encoding (PLAY = 1'b0, LOCKED = 1'b1)
  - BCD_MAX_DIGIT = 4'd9
  - winner bit indices (WIN_A = 0, WIN_B = 1)
- Sub-module bcd_score_cnt, instantiated once per team.
  - Inputs: clk, rst_n, clr, en, inc, dec.
  - Outputs: tens, ones, changed.
  - Implements saturating 00..99 BCD up/down.
  - en is driven low by the top when LOCKED.
- Edge detectors, FSM and winner compare stay in score_keeper.

Test Plan:
1. Reset, then a_inc high for 50 cycles -> A = 01 after 2 posedges; single chg pulse; B = 00.
2. 10 separate a_inc presses from 00 -> A = 10 (ones wraps 9 -> 0, tens 0 -> 1); 10 chg pulses; then 11 a_dec presses -> A = 00, last press gives no chg.
3. WIN_SCORE = 21: drive B to 20, then b_inc and a_dec same cycle -> B = 21, winner = 2'b10, LOCKED; further a_inc/b_inc -> no change, no chg.
4. A = 20, B = 20, a_inc and b_inc in the same cycle -> winner = 2'b11, scores 21/21.
5. LOCKED at 21/15, clr and a_inc same cycle -> 00/00, winner 00, PLAY, one chg; next a_inc -> A = 01.
6. WIN_SCORE = 99: A at 98, a_inc, then a_inc and a_dec together -> 99, lock, no further change. Separately: rst_n low mid-pulse with a_inc held -> after release A = 01.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the two-team score keeper.
// Contents: FSM state encoding, BCD digit limits, winner bit positions,
// and the packed button bundle used by the edge detectors.
package score_keeper_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned WINNER_W = 2;

  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO      = 4'd0;

  // Bit positions inside the winner vector
  localparam int unsigned WIN_A = 0;
  localparam int unsigned WIN_B = 1;

  typedef enum logic {
    PLAY   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // One bit per debounced button, in a fixed order
  typedef struct packed {
    logic clr;
    logic b_dec;
    logic b_inc;
    logic a_dec;
    logic a_inc;
  } btn_t;

endpackage

// File: rtl/score_keeper_bcd_cnt.sv
// Saturating two-digit BCD up/down counter (00..99), one per team.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   clr          - force 00 and strobe changed, regardless of en
//   en           - allow inc/dec steps (low while the board is locked)
//   inc, dec     - single-cycle step requests; both together cancel
//   tens, ones   - registered BCD digits
//   changed      - registered strobe, high the cycle after any move or clr
//   tens_nxt_c   - combinational next tens digit (for win lookahead)
//   ones_nxt_c   - combinational next ones digit (for win lookahead)
module bcd_score_cnt
  import score_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               changed,
  output logic [DIGIT_W-1:0] tens_nxt_c,
  output logic [DIGIT_W-1:0] ones_nxt_c
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               changed_q, changed_d;

  logic step_up;
  logic step_dn;
  logic at_max;
  logic at_min;

  assign step_up = en & inc & ~dec;
  assign step_dn = en & dec & ~inc;
  assign at_max  = (tens_q == BCD_MAX_DIGIT) && (ones_q == BCD_MAX_DIGIT);
  assign at_min  = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);

  // Next-value logic: clr wins, then a single saturating BCD step
  always_comb begin
    tens_d    = tens_q;
    ones_d    = ones_q;
    changed_d = 1'b0;
    if (clr) begin
      tens_d    = BCD_ZERO;
      ones_d    = BCD_ZERO;
      changed_d = 1'b1;
    end else if (step_up && !at_max) begin
      changed_d = 1'b1;
      if (ones_q == BCD_MAX_DIGIT) begin
        ones_d = BCD_ZERO;
        tens_d = tens_q + DIGIT_W'(1);
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end else if (step_dn && !at_min) begin
      changed_d = 1'b1;
      if (ones_q == BCD_ZERO) begin
        ones_d = BCD_MAX_DIGIT;
        tens_d = tens_q - DIGIT_W'(1);
      end else begin
        ones_d = ones_q - DIGIT_W'(1);
      end
    end
  end

  // Digit and strobe registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q    <= BCD_ZERO;
      ones_q    <= BCD_ZERO;
      changed_q <= 1'b0;
    end else begin
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      changed_q <= changed_d;
    end
  end

  assign tens       = tens_q;
  assign ones       = ones_q;
  assign changed    = changed_q;
  assign tens_nxt_c = tens_d;
  assign ones_nxt_c = ones_d;

endmodule

// File: rtl/score_keeper.sv
// Two-team scoreboard: edge-detects debounced buttons, keeps two BCD
// scores, locks the board once a team reaches WIN_SCORE until cleared.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   a_inc/a_dec/b_inc/b_dec    - debounced team buttons (level, any length)
//   clr                        - debounced clear/unlock button
//   a_tens/a_ones/b_tens/b_ones- BCD score digits
//   winner                     - bit0 team A won, bit1 team B won
//   chg                        - one-cycle strobe after any score/winner/clear change
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_inc,
  input  logic                a_dec,
  input  logic                b_inc,
  input  logic                b_dec,
  input  logic                clr,
  output logic [DIGIT_W-1:0]  a_tens,
  output logic [DIGIT_W-1:0]  a_ones,
  output logic [DIGIT_W-1:0]  b_tens,
  output logic [DIGIT_W-1:0]  b_ones,
  output logic [WINNER_W-1:0] winner,
  output logic                chg
);

  localparam logic [DIGIT_W-1:0] WIN_TENS = DIGIT_W'(WIN_SCORE / 10);
  localparam logic [DIGIT_W-1:0] WIN_ONES = DIGIT_W'(WIN_SCORE % 10);

  btn_t btn_in;
  btn_t s1_q, s1_d;
  btn_t s2_q, s2_d;
  btn_t press;

  state_e              state_q, state_d;
  logic [WINNER_W-1:0] winner_q, winner_d;

  logic               play_en;
  logic               hit_a;
  logic               hit_b;
  logic               a_changed;
  logic               b_changed;
  logic [DIGIT_W-1:0] a_tens_nxt, a_ones_nxt;
  logic [DIGIT_W-1:0] b_tens_nxt, b_ones_nxt;

  // Bundle the raw buttons
  always_comb begin
    btn_in       = '0;
    btn_in.clr   = clr;
    btn_in.b_dec = b_dec;
    btn_in.b_inc = b_inc;
    btn_in.a_dec = a_dec;
    btn_in.a_inc = a_inc;
  end

  // Two-flop history per button; a press is a rising edge of s1
  always_comb begin
    s1_d = btn_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign press   = s1_q & ~s2_q;
  assign play_en = (state_q == PLAY);

  bcd_score_cnt u_cnt_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (press.clr),
    .en         (play_en),
    .inc        (press.a_inc),
    .dec        (press.a_dec),
    .tens       (a_tens),
    .ones       (a_ones),
    .changed    (a_changed),
    .tens_nxt_c (a_tens_nxt),
    .ones_nxt_c (a_ones_nxt)
  );

  bcd_score_cnt u_cnt_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (press.clr),
    .en         (play_en),
    .inc        (press.b_inc),
    .dec        (press.b_dec),
    .tens       (b_tens),
    .ones       (b_ones),
    .changed    (b_changed),
    .tens_nxt_c (b_tens_nxt),
    .ones_nxt_c (b_ones_nxt)
  );

  // Compare the scores the counters are about to load, so the lock and
  // winner land on the same edge as the winning point.
  assign hit_a = (a_tens_nxt == WIN_TENS) && (a_ones_nxt == WIN_ONES);
  assign hit_b = (b_tens_nxt == WIN_TENS) && (b_ones_nxt == WIN_ONES);

  // Next-state / winner logic
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    if (press.clr) begin
      state_d  = PLAY;
      winner_d = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (hit_a || hit_b) begin
            state_d         = LOCKED;
            winner_d[WIN_A] = hit_a;
            winner_d[WIN_B] = hit_b;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  assign winner = winner_q;

  // Winner only moves together with a score move or a clear, and clear
  // strobes both counters, so the two registered strobes cover every case.
  assign chg = a_changed | b_changed;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper. Two instances (WIN_SCORE 21 and 99)
// share the same button stimulus; a behavioural model in plain integers
// predicts each, expectations go through a scoreboard queue.
module tb_score_keeper;

  localparam logic [4:0] B_A_INC = 5'b00001;
  localparam logic [4:0] B_A_DEC = 5'b00010;
  localparam logic [4:0] B_B_INC = 5'b00100;
  localparam logic [4:0] B_B_DEC = 5'b01000;
  localparam logic [4:0] B_CLR   = 5'b10000;

  typedef struct packed {
    logic [3:0] at;
    logic [3:0] ao;
    logic [3:0] bt;
    logic [3:0] bo;
    logic [1:0] w;
  } snap_t;

  typedef struct {
    snap_t s;
    int    chg_n;
    int    base;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, a_inc, a_dec, b_inc, b_dec, clr;

  logic [3:0] at0, ao0, bt0, bo0, at1, ao1, bt1, bo1;
  logic [1:0] w0, w1;
  logic       chg0, chg1;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cnt[2]  = '{0, 0};
  exp_t  exp_q[$];

  int         m_a[2];
  int         m_b[2];
  int         m_lock[2];
  int         m_chg[2];
  logic [1:0] m_w[2];
  int         win_of[2] = '{21, 99};

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(21)) dut21 (
    .clk(clk), .rst_n(rst_n), .a_inc(a_inc), .a_dec(a_dec), .b_inc(b_inc),
    .b_dec(b_dec), .clr(clr), .a_tens(at0), .a_ones(ao0), .b_tens(bt0),
    .b_ones(bo0), .winner(w0), .chg(chg0)
  );

  score_keeper #(.WIN_SCORE(99)) dut99 (
    .clk(clk), .rst_n(rst_n), .a_inc(a_inc), .a_dec(a_dec), .b_inc(b_inc),
    .b_dec(b_dec), .clr(clr), .a_tens(at1), .a_ones(ao1), .b_tens(bt1),
    .b_ones(bo1), .winner(w1), .chg(chg1)
  );

  // chg is high for whole cycles, so each pulse is seen by exactly one negedge
  always @(negedge clk) begin
    if (chg0 === 1'b1) cnt[0] <= cnt[0] + 1;
    if (chg1 === 1'b1) cnt[1] <= cnt[1] + 1;
  end

  function automatic snap_t obs(input int d);
    if (d == 0) return {at0, ao0, bt0, bo0, w0};
    return {at1, ao1, bt1, bo1, w1};
  endfunction

  function automatic snap_t model_snap(input int d);
    return {4'(m_a[d] / 10), 4'(m_a[d] % 10), 4'(m_b[d] / 10), 4'(m_b[d] % 10), m_w[d]};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_a[d] = 0; m_b[d] = 0; m_lock[d] = 0; m_chg[d] = 0; m_w[d] = 2'b00;
    end
  endfunction

  function automatic void model_apply(input int d, input logic [4:0] btn);
    int na, nb;
    m_chg[d] = 0;
    if (btn[4]) begin
      m_a[d] = 0; m_b[d] = 0; m_w[d] = 2'b00; m_lock[d] = 0; m_chg[d] = 1;
      return;
    end
    if (m_lock[d] != 0) return;
    na = m_a[d];
    nb = m_b[d];
    if (btn[0] && !btn[1] && na < 99) na = na + 1;
    else if (btn[1] && !btn[0] && na > 0) na = na - 1;
    if (btn[2] && !btn[3] && nb < 99) nb = nb + 1;
    else if (btn[3] && !btn[2] && nb > 0) nb = nb - 1;
    if (na != m_a[d] || nb != m_b[d]) m_chg[d] = 1;
    m_a[d] = na;
    m_b[d] = nb;
    if (na == win_of[d] || nb == win_of[d]) begin
      m_lock[d] = 1;
      m_w[d]    = {nb == win_of[d], na == win_of[d]};
    end
  endfunction

  task automatic drive(input logic [4:0] btn);
    {clr, b_dec, b_inc, a_dec, a_inc} = btn;
  endtask

  // Drive one press held for 'hold' posedges, record the expected outcome
  task automatic press(input logic [4:0] btn, input int hold, input int d);
    exp_t e;
    @(negedge clk);
    drive(btn);
    model_apply(0, btn);
    model_apply(1, btn);
    #1;
    e.s     = model_snap(d);
    e.chg_n = m_chg[d];
    e.base  = cnt[d];
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    drive(5'b0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'b0);
    repeat (3) @(negedge clk);
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs(d) !== model_snap(d)) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h want %h", d, obs(d), model_snap(d));
      end
    end
    n_tests++;
    if ({chg0, chg1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_chg: got %b want 00", {chg0, chg1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_long_hold();
    exp_t e;
    int   base;
    @(negedge clk);
    drive(B_A_INC);
    model_apply(0, B_A_INC);
    model_apply(1, B_A_INC);
    #1;
    base    = cnt[0];
    e.s     = model_snap(0);
    e.chg_n = m_chg[0];
    e.base  = base;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    n_tests++;
    if (ao0 !== 4'd0) begin
      n_fail++;
      $display("FAIL hold_latency_early: got a_ones %0d want 0", ao0);
    end
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (obs(0) !== e.s) begin
      n_fail++;
      $display("FAIL hold_latency_2: got %h want %h", obs(0), e.s);
    end
    n_tests++;
    if (chg0 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_chg_now: got %b want 1", chg0);
    end
    repeat (48) @(negedge clk);
    drive(5'b0);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (obs(0) !== model_snap(0) || cnt[0] - base !== 1) begin
      n_fail++;
      $display("FAIL hold_single_press: got %h/%0d pulses want %h/1", obs(0), cnt[0] - base, model_snap(0));
    end
  endtask

  // Run a stimulus list against one instance, checking every step
  task automatic run_steps(input string name, input logic [4:0] steps[$], input int d);
    exp_t e;
    for (int i = 0; i < steps.size(); i++) begin
      press(steps[i], 1 + (i % 3), d);
      e = exp_q.pop_front();
      n_tests++;
      if (obs(d) !== e.s) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h want %h", name, i, obs(d), e.s);
      end
      n_tests++;
      if (cnt[d] - e.base !== e.chg_n) begin
        n_fail++;
        $display("FAIL %s_chg step %0d: got %0d pulses want %0d", name, i, cnt[d] - e.base, e.chg_n);
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [4:0] s[$];
    s.push_back(B_CLR);
    repeat (10) s.push_back(B_A_INC);
    repeat (11) s.push_back(B_A_DEC);
    run_steps("count_wrap", s, 0);
  endtask

  task automatic test_win_b();
    logic [4:0] s[$];
    s.push_back(B_CLR);
    repeat (20) s.push_back(B_B_INC);
    s.push_back(B_B_INC | B_A_DEC);
    s.push_back(B_A_INC);
    s.push_back(B_B_INC);
    s.push_back(B_A_INC | B_B_DEC);
    run_steps("win_b", s, 0);
  endtask

  task automatic test_win_both();
    logic [4:0] s[$];
    s.push_back(B_CLR);
    repeat (21) s.push_back(B_A_INC | B_B_INC);
    s.push_back(B_B_DEC);
    run_steps("win_both", s, 0);
  endtask

  task automatic test_clr_locked();
    logic [4:0] s[$];
    s.push_back(B_CLR);
    repeat (15) s.push_back(B_B_INC);
    repeat (21) s.push_back(B_A_INC);
    s.push_back(B_CLR | B_A_INC);
    s.push_back(B_A_INC);
    s.push_back(B_CLR);
    s.push_back(B_CLR);
    run_steps("clr_locked", s, 0);
  endtask

  task automatic test_win99();
    logic [4:0] s[$];
    s.push_back(B_CLR);
    repeat (98) s.push_back(B_A_INC);
    s.push_back(B_A_INC);
    s.push_back(B_A_INC | B_A_DEC);
    s.push_back(B_A_INC);
    s.push_back(B_A_DEC);
    run_steps("win99", s, 1);
  endtask

  task automatic test_reset_mid_press();
    exp_t e;
    @(negedge clk);
    drive(B_A_INC);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    model_apply(0, B_A_INC);
    model_apply(1, B_A_INC);
    #1;
    for (int d = 0; d < 2; d++) begin
      e.s     = model_snap(d);
      e.chg_n = 1;
      e.base  = cnt[d];
      exp_q.push_back(e);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    drive(5'b0);
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs(d) !== e.s || cnt[d] - e.base !== e.chg_n) begin
        n_fail++;
        $display("FAIL reset_mid_press dut%0d: got %h/%0d pulses want %h/%0d",
                 d, obs(d), cnt[d] - e.base, e.s, e.chg_n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'b0);
    test_reset();
    test_long_hold();
    test_count_wrap();
    test_win_b();
    test_win_both();
    test_clr_locked();
    test_win99();
    test_reset_mid_press();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
